// File: rtl/sub_share_arb.sv
`default_nettype none
// ============================================================================
// Module  : sub_share_arb
// Brief   : Round-robin shared (A - B - CI) subtractor with per-request lock
//           and a one-entry tagged result register with backpressure.
// Revision: 1.0 - initial release
// ============================================================================
module sub_share_arb #(
  parameter int WIDTH = 18,
  parameter int NREQ  = 4,
  parameter int TAGW  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ-1:0]       req_lock,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_ci,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_diff,
  output logic                  out_co,
  output logic [TAGW-1:0]       out_tag,
  output logic                  out_last
);

  // Reject configurations whose tag cannot name every requester.
  generate
    if (NREQ < 2 || NREQ > 16 || (2**TAGW) < NREQ) begin : g_cfg_err
      $error("sub_share_arb: NREQ must be 2..16 and 2**TAGW >= NREQ");
    end
  endgenerate

  localparam logic [0:0] S_ARB    = 1'b0;
  localparam logic [0:0] S_LOCKED = 1'b1;

  logic [0:0]        r_state, w_state_nxt;
  logic [TAGW-1:0]   r_ptr, w_ptr_nxt;
  logic [TAGW-1:0]   r_owner, w_owner_nxt;

  logic              w_space;
  logic              w_gnt_found;
  logic [TAGW-1:0]   w_gnt_idx;
  logic [TAGW-1:0]   w_sel;
  logic              w_xfer;
  logic [2*NREQ-1:0] w_rot;
  logic [WIDTH-1:0]  w_a, w_b;
  logic              w_ci, w_lock;
  logic [WIDTH:0]    w_sub;

  logic              r_valid;
  logic [WIDTH-1:0]  r_diff;
  logic              r_co;
  logic [TAGW-1:0]   r_tag;
  logic              r_last;

  // The result slot can accept a new word when empty or being drained now.
  assign w_space = !r_valid || out_ready;

  // Rotate the valid vector so bit 0 is the pointer position; the lowest set
  // bit of the rotated view is the round-robin winner.
  assign w_rot = {req_valid, req_valid} >> r_ptr;

  // Round-robin search starting at the pointer.
  always_comb begin
    int v_sum;
    v_sum       = 0;
    w_gnt_found = 1'b0;
    w_gnt_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        v_sum = int'(r_ptr) + k;
        if (v_sum >= NREQ) v_sum = v_sum - NREQ;
        w_gnt_found = 1'b1;
        w_gnt_idx   = TAGW'(v_sum);
      end
    end
  end

  // While locked only the owner can be served, otherwise the rr winner.
  assign w_sel  = (r_state == S_LOCKED) ? r_owner : w_gnt_idx;
  assign w_a    = req_a[int'(w_sel)*WIDTH +: WIDTH];
  assign w_b    = req_b[int'(w_sel)*WIDTH +: WIDTH];
  assign w_ci   = req_ci[w_sel];
  assign w_lock = req_lock[w_sel];
  assign w_xfer = |(req_valid & req_ready);

  // Borrow-out falls out as bit WIDTH of the zero-extended difference.
  assign w_sub = {1'b0, w_a} - {1'b0, w_b} - {{WIDTH{1'b0}}, w_ci};

  // FSM output: grant at most one requester, none while the slot is full.
  always_comb begin
    req_ready = '0;
    if (w_space) begin
      if (r_state == S_LOCKED) begin
        req_ready[r_owner] = req_valid[r_owner];
      end else if (w_gnt_found) begin
        req_ready[w_gnt_idx] = 1'b1;
      end
    end
  end

  // FSM next state: pointer advances past every served requester.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_owner_nxt = r_owner;
    if (w_xfer) begin
      w_ptr_nxt = (int'(w_sel) == NREQ - 1) ? '0 : w_sel + TAGW'(1);
      case (r_state)
        S_ARB: begin
          if (w_lock) begin
            w_state_nxt = S_LOCKED;
            w_owner_nxt = w_sel;
          end
        end
        S_LOCKED: begin
          if (!w_lock) w_state_nxt = S_ARB;
        end
        default: w_state_nxt = S_ARB;
      endcase
    end
  end

  // FSM state register with pointer and lock owner.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_ARB;
      r_ptr   <= '0;
      r_owner <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_owner <= w_owner_nxt;
    end
  end

  // Result register: a transfer overwrites (also when draining), else drain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_diff  <= '0;
      r_co    <= 1'b0;
      r_tag   <= '0;
      r_last  <= 1'b0;
    end else if (w_xfer) begin
      r_valid <= 1'b1;
      r_diff  <= w_sub[WIDTH-1:0];
      r_co    <= w_sub[WIDTH];
      r_tag   <= w_sel;
      r_last  <= !w_lock;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign out_diff  = r_diff;
  assign out_co    = r_co;
  assign out_tag   = r_tag;
  assign out_last  = r_last;

endmodule
`default_nettype wire

// File: tb/tb_sub_share_arb.sv
`default_nettype none
// ============================================================================
// Module  : tb_sub_share_arb
// Brief   : Self-checking bench for sub_share_arb (WIDTH=8, NREQ=4).
// Revision: 1.0 - initial release
// ============================================================================
module tb_sub_share_arb;
  localparam int W  = 8;
  localparam int N  = 4;
  localparam int TW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid, req_ready, req_lock, req_ci;
  logic [N*W-1:0] req_a, req_b;
  logic           out_valid, out_ready, out_co, out_last;
  logic [W-1:0]   out_diff;
  logic [TW-1:0]  out_tag;

  sub_share_arb #(.WIDTH(W), .NREQ(N), .TAGW(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_lock(req_lock),
    .req_a(req_a), .req_b(req_b), .req_ci(req_ci),
    .out_valid(out_valid), .out_ready(out_ready), .out_diff(out_diff),
    .out_co(out_co), .out_tag(out_tag), .out_last(out_last)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: abstract arbiter state plus the expected result slot.
  bit       m_valid;
  bit [7:0] m_diff;
  bit       m_co;
  int       m_tag;
  bit       m_last;
  int       m_ptr;
  bit       m_locked;
  int       m_owner;
  logic [N-1:0] m_rdy;
  logic [N-1:0] m_gnt = '0;

  typedef struct {
    int       r;
    logic [7:0] a;
    logic [7:0] b;
    logic     ci;
    logic [7:0] d;
    logic     co;
  } vec_t;
  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [N-1:0] model_ready();
    logic [N-1:0] r;
    int i;
    r = '0;
    if (m_valid && !out_ready) return r;
    if (m_locked) begin
      r[m_owner] = req_valid[m_owner];
      return r;
    end
    for (int k = 0; k < N; k++) begin
      i = (m_ptr + k) % N;
      if (req_valid[i]) begin
        r[i] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b,
                         input logic ci, input logic lk);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_ci[i]       = ci;
    req_lock[i]     = lk;
  endtask

  // One clock: check grants and outputs against the model, then advance it.
  task automatic cycle();
    int g;
    int d;
    @(negedge clk);
    m_rdy = model_ready();
    m_gnt = m_rdy & req_valid;
    check("req_ready", 32'(req_ready), 32'(m_rdy));
    check("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid) begin
      check("out_diff", 32'(out_diff), 32'(m_diff));
      check("out_co",   32'(out_co),   32'(m_co));
      check("out_tag",  32'(out_tag),  32'(m_tag));
      check("out_last", 32'(out_last), 32'(m_last));
    end
    @(posedge clk);
    if (!rst_n) begin
      m_valid = 0; m_diff = 0; m_co = 0; m_tag = 0; m_last = 0;
      m_ptr = 0; m_locked = 0; m_owner = 0;
    end else begin
      g = -1;
      for (int i = 0; i < N; i++) if (m_gnt[i]) g = i;
      if (g >= 0) begin
        d = int'(req_a[g*W +: W]) - int'(req_b[g*W +: W]) - int'(req_ci[g]);
        m_diff   = d[7:0];
        m_co     = (d < 0);
        m_tag    = g;
        m_last   = !req_lock[g];
        m_valid  = 1;
        m_ptr    = (g + 1) % N;
        m_locked = req_lock[g];
        if (req_lock[g]) m_owner = g;
      end else if (out_ready) begin
        m_valid = 0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_valid"}, 32'(out_valid), 0);
    check({pfx, "_diff"},  32'(out_diff),  0);
    check({pfx, "_co"},    32'(out_co),    0);
    check({pfx, "_tag"},   32'(out_tag),   0);
    check({pfx, "_last"},  32'(out_last),  0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] s_diff;
    logic [TW-1:0] s_tag;
    logic s_co;

    tbl[0] = '{0, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b1};
    tbl[1] = '{1, 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0};
    tbl[2] = '{2, 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
    tbl[3] = '{3, 8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0};
    tbl[4] = '{0, 8'h80, 8'h7F, 1'b1, 8'h00, 1'b0};
    tbl[5] = '{1, 8'h00, 8'hFF, 1'b0, 8'h01, 1'b1};
    tbl[6] = '{2, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    tbl[7] = '{3, 8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1};

    rst_n = 1'b0; req_valid = '0; req_lock = '0; req_ci = '0;
    req_a = '0; req_b = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;

    // Table-driven single-requester arithmetic, 1-cycle latency.
    for (int k = 0; k < 8; k++) begin
      req_valid = '0;
      req_valid[tbl[k].r] = 1'b1;
      set_req(tbl[k].r, tbl[k].a, tbl[k].b, tbl[k].ci, 1'b0);
      cycle();
      req_valid = '0;
      check("vec_valid", 32'(out_valid), 1);
      check("vec_diff",  32'(out_diff),  32'(tbl[k].d));
      check("vec_co",    32'(out_co),    32'(tbl[k].co));
      check("vec_tag",   32'(out_tag),   32'(tbl[k].r));
      check("vec_last",  32'(out_last),  1);
    end
    cycle();

    // Round-robin with all four requesters valid.
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 8'(i * 17), 8'(i * 3), 1'b0, 1'b0);
    req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      cycle();
      check("rr_tag", 32'(out_tag), 32'(k % N));
    end
    req_valid = '0;
    cycle();

    // Locked 3-word burst from requester 2 while others wait.
    do_reset();
    req_valid = 4'b0010;
    cycle();
    req_valid = '1;
    set_req(2, 8'h11, 8'h22, 1'b0, 1'b1);
    cycle();
    check("lock_tag0", 32'(out_tag), 2);
    check("lock_last0", 32'(out_last), 0);
    set_req(2, 8'h33, 8'h01, 1'b1, 1'b1);
    cycle();
    check("lock_tag1", 32'(out_tag), 2);
    check("lock_last1", 32'(out_last), 0);
    set_req(2, 8'h44, 8'h04, 1'b1, 1'b0);
    cycle();
    check("lock_tag2", 32'(out_tag), 2);
    check("lock_last2", 32'(out_last), 1);
    cycle();
    check("lock_after", 32'(out_tag), 3);

    // Backpressure: 5 stalled cycles then drain-and-reload with no bubble.
    out_ready = 1'b0;
    s_diff = out_diff; s_tag = out_tag; s_co = out_co;
    for (int k = 0; k < 5; k++) begin
      cycle();
      check("bp_ready", 32'(req_ready), 0);
      check("bp_valid", 32'(out_valid), 1);
      check("bp_diff",  32'(out_diff),  32'(s_diff));
      check("bp_tag",   32'(out_tag),   32'(s_tag));
      check("bp_co",    32'(out_co),    32'(s_co));
    end
    out_ready = 1'b1;
    #1;
    check("bp_release", 32'(|req_ready), 1);
    cycle();
    check("bp_nobubble", 32'(out_valid), 1);
    check("bp_newtag", 32'((int'(s_tag) + 1) % N), 32'(out_tag));
    req_valid = '0;
    cycle();

    // Reset in the middle of a locked burst owned by requester 1.
    do_reset();
    req_valid = 4'b0001;
    set_req(0, 8'h09, 8'h02, 1'b0, 1'b0);
    cycle();
    req_valid = 4'b0010;
    set_req(1, 8'h50, 8'h20, 1'b0, 1'b1);
    cycle();
    check("mid_valid", 32'(out_valid), 1);
    req_valid = 4'b0011;
    rst_n = 1'b0;
    cycle();
    check_zero("midrst");
    rst_n = 1'b1;
    #1;
    check("midrst_grant", 32'(req_ready), 32'(4'b0001));
    cycle();
    req_valid = '0;
    cycle();

    // Randomized traffic against the model; waiting requests hold steady.
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!(req_valid[i] && !m_gnt[i])) begin
          req_valid[i] = ($urandom_range(0, 9) < 6);
          set_req(i, 8'($urandom), 8'($urandom), 1'($urandom),
                  ($urandom_range(0, 9) < 3));
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
